// File: rtl/mmio_led_pkg.sv
// Shared definitions for the memory-mapped LED controller: register word
// offsets within the peripheral window and the per-channel mode encodings.
package mmio_led_pkg;

  localparam logic [2:0] OFF_DATA     = 3'd0;
  localparam logic [2:0] OFF_SET      = 3'd1;
  localparam logic [2:0] OFF_CLR      = 3'd2;
  localparam logic [2:0] OFF_MODE     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;
  localparam logic [2:0] OFF_DUTY     = 3'd5;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_OFF    = 2'b11
  } led_mode_e;

  // Word offsets 6 and 7 of the window are unmapped.
  function automatic logic is_mapped_offset(input logic [2:0] off);
    return off <= OFF_DUTY;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable prescaler: counts 0..period and emits a one-cycle tick on
// the cycle where the count sits at period. A clear (issued when software
// rewrites the period) restarts the count and swallows that cycle's tick.
module led_tick_gen #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic [DIV_W-1:0] period,
  input  logic             clear,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             at_top;

  assign at_top = (count == period);
  assign tick   = at_top & ~clear;

  // Free-running count that wraps at the programmed period or on a clear.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count <= '0;
    end else if (clear || at_top) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_led_ctrl.sv
// Memory-mapped LED/GPIO output peripheral for the core data bus.
// Channels can be static, blinking, PWM-dimmed or forced off; a shared
// prescaler tick paces blink phase and PWM so the LEDs stay visible while
// the core runs at full clock. Register offsets count from BASE_ADDR.
// Build option: define MMIO_LED_READBACK_EN to get the registered read mux;
// without it bus_rdata is tied to zero and only the write path exists.
module mmio_led_ctrl #(
  parameter int                N_LED      = 6,
  parameter logic [31:0]       BASE_ADDR  = 32'h0000_0008,
  parameter bit                ACTIVE_LOW = 1'b1,
  parameter int                DIV_W      = 24,
  parameter logic [DIV_W-1:0]  RESET_DIV  = DIV_W'(13_499_999),
  parameter int                PWM_BITS   = 8
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic [31:0]      bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  output logic [31:0]      bus_rdata,
  output logic [N_LED-1:0] led
);

  import mmio_led_pkg::*;

  logic [N_LED-1:0]    data_q;
  logic [2*N_LED-1:0]  mode_q;
  logic [DIV_W-1:0]    prescale_q;
  logic [PWM_BITS-1:0] duty_q;
  logic                phase_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [N_LED-1:0]    led_q;

  logic [31:0]         rel_addr;
  logic [2:0]          offset;
  logic                hit;
  logic                wr_hit;
  logic                prescale_wr;
  logic                tick;
  logic                pwm_on;
  logic [N_LED-1:0]    lit;
  logic                unused_bits;

  assign rel_addr    = bus_addr - BASE_ADDR;
  assign offset      = rel_addr[4:2];
  assign hit         = (rel_addr[31:5] == '0) && is_mapped_offset(offset);
  assign wr_hit      = bus_we && hit;
  assign prescale_wr = wr_hit && (offset == OFF_PRESCALE);
  assign unused_bits = &{1'b0, rel_addr[1:0], bus_wdata};

  led_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .period    (prescale_q),
    .clear     (prescale_wr),
    .tick      (tick)
  );

  // Register file: SET/CLR are not storage, they edit DATA in place.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_q     <= '0;
      mode_q     <= '0;
      prescale_q <= RESET_DIV;
      duty_q     <= '0;
    end else if (wr_hit) begin
      case (offset)
        OFF_DATA:     data_q     <= bus_wdata[N_LED-1:0];
        OFF_SET:      data_q     <= data_q | bus_wdata[N_LED-1:0];
        OFF_CLR:      data_q     <= data_q & ~bus_wdata[N_LED-1:0];
        OFF_MODE:     mode_q     <= bus_wdata[2*N_LED-1:0];
        OFF_PRESCALE: prescale_q <= bus_wdata[DIV_W-1:0];
        OFF_DUTY:     duty_q     <= bus_wdata[PWM_BITS-1:0];
        default:      ;
      endcase
    end
  end

  // Blink phase and PWM ramp both advance only on prescaler ticks.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_q   <= 1'b0;
      pwm_cnt_q <= '0;
    end else if (tick) begin
      phase_q   <= ~phase_q;
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
    end
  end

  assign pwm_on = (pwm_cnt_q < duty_q);

  // Per-channel lit decision from its 2-bit mode field.
  always_comb begin
    lit = '0;
    for (int i = 0; i < N_LED; i++) begin
      case (led_mode_e'(mode_q[2*i +: 2]))
        MODE_STATIC: lit[i] = data_q[i];
        MODE_BLINK:  lit[i] = data_q[i] & phase_q;
        MODE_PWM:    lit[i] = data_q[i] & pwm_on;
        default:     lit[i] = 1'b0;
      endcase
    end
  end

  // Registered pins, inverted for boards where a low pin lights the LED.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_q <= {N_LED{ACTIVE_LOW}};
    end else begin
      led_q <= lit ^ {N_LED{ACTIVE_LOW}};
    end
  end

  assign led = led_q;

`ifdef MMIO_LED_READBACK_EN
  logic [31:0] rd_mux;
  logic [31:0] rdata_q;

  // Read mux; SET and CLR windows mirror DATA, everything else reads zero.
  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (offset)
        OFF_DATA, OFF_SET, OFF_CLR: rd_mux[N_LED-1:0]    = data_q;
        OFF_MODE:                   rd_mux[2*N_LED-1:0]  = mode_q;
        OFF_PRESCALE:               rd_mux[DIV_W-1:0]    = prescale_q;
        OFF_DUTY:                   rd_mux[PWM_BITS-1:0] = duty_q;
        default:                    rd_mux               = '0;
      endcase
    end
  end

  // Read data registered every cycle regardless of bus_we.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_mux;
    end
  end

  assign bus_rdata = rdata_q;
`else
  assign bus_rdata = '0;
`endif

endmodule

// File: tb/tb_mmio_led_ctrl.sv
// Scoreboard bench for mmio_led_ctrl. The stimulus thread drives bus cycles
// and queues hand-computed expectations tagged with the clock edge after
// which they must hold; a monitor on the falling edge pops and compares.
module tb_mmio_led_ctrl;

`ifdef MMIO_LED_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  localparam logic [31:0] RESET_PRESCALE = 32'd13_499_999;

  logic        clk;
  logic        sys_rst_n;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic [5:0]  led;

  typedef struct {
    int          at;
    bit          is_led;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   edge_cnt = 0;
  int   total    = 0;
  int   bad      = 0;

  mmio_led_ctrl dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_we    (bus_we),
    .bus_rdata (bus_rdata),
    .led       (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count active edges so expectations can name the edge they follow.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] rb(input logic [31:0] v);
    return READBACK ? v : 32'h0;
  endfunction

  task automatic pushExpect(input int at, input bit is_led, input logic [31:0] exp,
                            input string name);
    exp_t e;
    int   i;
    e.at = at; e.is_led = is_led; e.exp = exp; e.name = name;
    i = q.size();
    while (i > 0 && q[i-1].at > at) i--;
    q.insert(i, e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    act = e.is_led ? 32'(led) : bus_rdata;
    total++;
    if (act !== e.exp) begin
      bad++;
      $display("[TB] FAIL %s (edge %0d): got 0x%0h, want 0x%0h", e.name, e.at, act, e.exp);
    end
  endtask

  // Monitor: compare every expectation due by the edge just passed.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].at <= edge_cnt) begin
      checkOutput(q.pop_front());
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input bit we);
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_we    = we;
    @(negedge clk);
    bus_we    = 1'b0;
  endtask

  task automatic readCheck(input logic [31:0] addr, input logic [31:0] exp,
                           input string name);
    pushExpect(edge_cnt + 1, 1'b0, rb(exp), name);
    applyStimulus(addr, 32'h0, 1'b0);
  endtask

  task automatic idleUntil(input int target);
    while (edge_cnt < target) applyStimulus(bus_addr, 32'h0, 1'b0);
  endtask

  bit blink_lit [23];

  initial begin
    sys_rst_n = 1'b0;
    bus_addr  = 32'h0;
    bus_wdata = 32'h0;
    bus_we    = 1'b0;
    blink_lit = '{0,0,1,1,1,1,0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0,1};

    $display("[TB] reset");
    pushExpect(1, 1'b1, 32'h3F, "rst_led");
    pushExpect(1, 1'b0, 32'h0,  "rst_rdata");
    pushExpect(2, 1'b1, 32'h3F, "rst_led");
    pushExpect(2, 1'b0, 32'h0,  "rst_rdata");
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    pushExpect(4, 1'b1, 32'h3F, "post_rst_led");
    readCheck(32'h18, RESET_PRESCALE, "rst_prescale");

    $display("[TB] static DATA/SET/CLR");
    pushExpect(edge_cnt + 1, 1'b0, 32'h0,  "rd_old_data");
    pushExpect(edge_cnt + 1, 1'b1, 32'h3F, "data_led_lag");
    pushExpect(edge_cnt + 2, 1'b1, 32'h15, "data_led");
    applyStimulus(32'h08, 32'h2A, 1'b1);
    pushExpect(edge_cnt + 1, 1'b0, rb(32'h2A), "rd_set_win");
    pushExpect(edge_cnt + 2, 1'b1, 32'h14, "set_led");
    applyStimulus(32'h0C, 32'h01, 1'b1);
    pushExpect(edge_cnt + 1, 1'b0, rb(32'h2B), "rd_clr_win");
    pushExpect(edge_cnt + 2, 1'b1, 32'h1C, "clr_led");
    applyStimulus(32'h10, 32'h08, 1'b1);
    readCheck(32'h08, 32'h23, "rd_data_after_clr");

    $display("[TB] blink");
    pushExpect(edge_cnt + 1, 1'b0, rb(RESET_PRESCALE), "rd_old_prescale");
    applyStimulus(32'h18, 32'h3, 1'b1);
    applyStimulus(32'h14, 32'h1, 1'b1);
    applyStimulus(32'h08, 32'h1, 1'b1);
    for (int k = 0; k < 23; k++) begin
      pushExpect(12 + k, 1'b1, blink_lit[k] ? 32'h3E : 32'h3F, $sformatf("blink_e%0d", 12 + k));
    end
    idleUntil(24);
    applyStimulus(32'h18, 32'h3, 1'b1);
    idleUntil(34);

    $display("[TB] reset mid-operation");
    @(posedge clk);
    #2;
    sys_rst_n = 1'b0;
    pushExpect(edge_cnt, 1'b1, 32'h3F, "async_rst_led");
    pushExpect(edge_cnt, 1'b0, 32'h0,  "async_rst_rdata");
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    pushExpect(edge_cnt + 1, 1'b1, 32'h3F, "rst2_led");
    readCheck(32'h14, 32'h0, "rst2_mode");
    readCheck(32'h08, 32'h0, "rst2_data");
    readCheck(32'h18, RESET_PRESCALE, "rst2_prescale");

    $display("[TB] pwm");
    applyStimulus(32'h18, 32'h0, 1'b1);
    applyStimulus(32'h1C, 32'hABCD_0040, 1'b1);
    applyStimulus(32'h14, 32'hFFFF_F008, 1'b1);
    for (int e = 44; e <= 361; e++) begin
      pushExpect(e, 1'b1, ((e >= 45) && (((e - 42) % 256) < 64)) ? 32'h3D : 32'h3F, "pwm_duty64");
    end
    applyStimulus(32'h08, 32'hFFFF_FFC2, 1'b1);
    idleUntil(361);
    for (int e = 363; e <= 620; e++) begin
      pushExpect(e, 1'b1, (((e - 42) % 256) != 255) ? 32'h3D : 32'h3F, "pwm_duty255");
    end
    applyStimulus(32'h1C, 32'hFF, 1'b1);
    idleUntil(620);
    for (int e = 622; e <= 900; e++) begin
      pushExpect(e, 1'b1, 32'h3F, "pwm_duty0");
    end
    applyStimulus(32'h1C, 32'h0, 1'b1);
    idleUntil(900);

    $display("[TB] address decode");
    pushExpect(edge_cnt + 2, 1'b1, 32'h3F, "miss_led");
    pushExpect(edge_cnt + 3, 1'b1, 32'h3F, "miss_led");
    pushExpect(edge_cnt + 4, 1'b1, 32'h3F, "miss_led");
    applyStimulus(32'h20, 32'h3F, 1'b1);
    applyStimulus(32'h28, 32'h3F, 1'b1);
    pushExpect(edge_cnt + 1, 1'b0, 32'h0, "rd_miss_0x20");
    applyStimulus(32'h20, 32'h0, 1'b0);
    pushExpect(edge_cnt + 1, 1'b0, 32'h0, "rd_miss_0x28");
    applyStimulus(32'h28, 32'h0, 1'b0);
    readCheck(32'h08, 32'h02, "data_kept");
    pushExpect(edge_cnt + 1, 1'b1, 32'h3F, "unaligned_led_lag");
    pushExpect(edge_cnt + 2, 1'b1, 32'h2A, "unaligned_led");
    applyStimulus(32'h0A, 32'h15, 1'b1);
    readCheck(32'h0B, 32'h15, "rd_unaligned");
    readCheck(32'h14, 32'h008, "rd_mode_masked");
    repeat (3) @(negedge clk);

    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
